// File: rtl/multi_channel_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : multi_channel_clock_divider
//  Description : NUM_CH independent programmable clock dividers driven from
//                clk_in. Each channel has its own period, high time and run
//                enable. A valid/ready port reconfigures one channel at a
//                time, either restarting it immediately or deferring the new
//                setting glitch-free to the end of the current period.
//  Ports       : clk_in      - single clock, all logic on posedge
//                rst         - synchronous active-high reset
//                ch_en       - per-channel run enable (level)
//                cfg_valid   - configuration request
//                cfg_ready   - configuration accept (combinational on cfg_ch)
//                cfg_ch      - target channel
//                cfg_mode    - 0 = deferred to period boundary, 1 = immediate
//                cfg_period  - period in clk_in cycles (legal >= 2)
//                cfg_high    - high cycles per period (legal 1..period-1)
//                clk_out     - divided clocks (registered)
//                rise_pulse  - one-cycle strobe in the cycle clk_out rises
//                cfg_err     - one-cycle pulse after an illegal transfer
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_clock_divider #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 16,
    // Derived from NUM_CH; leave at its default.
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic                 cfg_mode,
    input  logic [DIV_WIDTH-1:0] cfg_period,
    input  logic [DIV_WIDTH-1:0] cfg_high,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    rise_pulse,
    output logic                 cfg_err
);

    localparam logic [DIV_WIDTH-1:0] c_RST_PERIOD = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] c_RST_HIGH   = DIV_WIDTH'(1);

    logic [NUM_CH-1:0] w_pending;
    logic              w_ch_ok;
    logic              w_ready;
    logic              w_legal;
    logic              w_xfer;
    logic              w_good;

    // cfg_ch may address a channel that does not exist (when NUM_CH is not a
    // power of two); such a channel never has anything pending, so ready=1.
    always_comb begin
        w_ready = 1'b1;
        w_ch_ok = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_ch_ok = 1'b1;
                if (w_pending[i]) begin
                    w_ready = 1'b0;
                end
            end
        end
    end

    assign cfg_ready = w_ready;
    assign w_legal   = w_ch_ok
                     && (cfg_period >= c_RST_PERIOD)
                     && (cfg_high != '0)
                     && (cfg_high < cfg_period);
    // Transfers presented while reset is asserted are dropped.
    assign w_xfer    = cfg_valid && w_ready && !rst;
    assign w_good    = w_xfer && w_legal;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= w_xfer && !w_legal;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_WIDTH-1:0] r_cnt;
        logic [DIV_WIDTH-1:0] r_period;
        logic [DIV_WIDTH-1:0] r_high;
        logic [DIV_WIDTH-1:0] r_sh_period;
        logic [DIV_WIDTH-1:0] r_sh_high;
        logic                 r_run;
        logic                 r_pend;
        logic                 r_clk;
        logic                 r_rise;
        logic                 w_sel;
        logic                 w_wrap;
        logic                 w_apply;
        logic [DIV_WIDTH-1:0] w_cnt_nxt;
        logic                 w_clk_nxt;

        assign w_sel     = w_good && (cfg_ch == CH_W'(gi));
        assign w_wrap    = (r_cnt == (r_period - DIV_WIDTH'(1)));
        assign w_cnt_nxt = w_wrap ? '0 : (r_cnt + DIV_WIDTH'(1));
        assign w_clk_nxt = (w_cnt_nxt < r_high);
        // A pending setting lands at the period boundary, or on the next
        // edge if the channel is not running (including while disabled).
        assign w_apply   = r_pend && (!ch_en[gi] || !r_run || w_wrap);

        always_ff @(posedge clk_in) begin
            if (rst) begin
                r_cnt       <= '0;
                r_run       <= 1'b0;
                r_clk       <= 1'b0;
                r_rise      <= 1'b0;
                r_pend      <= 1'b0;
                r_period    <= c_RST_PERIOD;
                r_high      <= c_RST_HIGH;
                r_sh_period <= c_RST_PERIOD;
                r_sh_high   <= c_RST_HIGH;
            end else begin
                // Configuration registers: immediate > new deferred > apply.
                // A new deferred request needs pending=0, so it never
                // coincides with an apply.
                if (w_sel && cfg_mode) begin
                    r_period <= cfg_period;
                    r_high   <= cfg_high;
                    r_pend   <= 1'b0;
                end else if (w_sel) begin
                    r_sh_period <= cfg_period;
                    r_sh_high   <= cfg_high;
                    r_pend      <= 1'b1;
                end else if (w_apply) begin
                    r_period <= r_sh_period;
                    r_high   <= r_sh_high;
                    r_pend   <= 1'b0;
                end

                // Waveform: disable > immediate restart / start > count.
                if (!ch_en[gi]) begin
                    r_cnt  <= '0;
                    r_run  <= 1'b0;
                    r_clk  <= 1'b0;
                    r_rise <= 1'b0;
                end else if ((w_sel && cfg_mode) || !r_run) begin
                    r_cnt  <= '0;
                    r_run  <= 1'b1;
                    r_clk  <= 1'b1;
                    r_rise <= ~r_clk;
                end else begin
                    // At a boundary w_cnt_nxt is 0 and high >= 1, so the new
                    // period (old or newly applied) always starts high.
                    r_cnt  <= w_cnt_nxt;
                    r_clk  <= w_clk_nxt;
                    r_rise <= w_clk_nxt & ~r_clk;
                end
            end
        end

        assign w_pending[gi]  = r_pend;
        assign clk_out[gi]    = r_clk;
        assign rise_pulse[gi] = r_rise;
    end : g_ch

endmodule : multi_channel_clock_divider
`default_nettype wire

// File: tb/tb_multi_channel_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_channel_clock_divider
//  Description : Directed self-checking bench for multi_channel_clock_divider
//                (3 channels, 8-bit dividers). Expected output vectors are
//                queued as each step is driven and compared after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_clock_divider;

    localparam int NUM_CH    = 3;
    localparam int DIV_WIDTH = 8;
    localparam int CH_W      = 2;

    logic                 clk_in = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    ch_en;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CH_W-1:0]      cfg_ch;
    logic                 cfg_mode;
    logic [DIV_WIDTH-1:0] cfg_period;
    logic [DIV_WIDTH-1:0] cfg_high;
    logic [NUM_CH-1:0]    clk_out;
    logic [NUM_CH-1:0]    rise_pulse;
    logic                 cfg_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string             tag;
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] rise;
        logic              err;
    } exp_t;

    exp_t sb[$];

    multi_channel_clock_divider #(
        .NUM_CH    (NUM_CH),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .ch_en      (ch_en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .clk_out    (clk_out),
        .rise_pulse (rise_pulse),
        .cfg_err    (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    // Queue the expected outputs for the coming edge, then compare 1 time
    // unit after it.
    task automatic expect_edge(input string tag, input logic [NUM_CH-1:0] c,
                               input logic [NUM_CH-1:0] r, input logic e);
        exp_t x;
        x.tag  = tag;
        x.clk  = c;
        x.rise = r;
        x.err  = e;
        sb.push_back(x);
        @(posedge clk_in);
        #1;
        x = sb.pop_front();
        checks++;
        assert ({clk_out, rise_pulse, cfg_err} === {x.clk, x.rise, x.err})
        else begin
            errors++;
            $error("FAIL %s: clk_out=%b rise=%b err=%b, expected clk_out=%b rise=%b err=%b",
                   x.tag, clk_out, rise_pulse, cfg_err, x.clk, x.rise, x.err);
        end
    endtask

    task automatic check_ready(input string tag, input logic exp);
        checks++;
        assert (cfg_ready === exp)
        else begin
            errors++;
            $error("FAIL %s: cfg_ready=%b, expected %b", tag, cfg_ready, exp);
        end
    endtask

    task automatic drive_cfg(input logic v, input logic [CH_W-1:0] ch, input logic m,
                             input logic [DIV_WIDTH-1:0] p, input logic [DIV_WIDTH-1:0] h);
        cfg_valid  = v;
        cfg_ch     = ch;
        cfg_mode   = m;
        cfg_period = p;
        cfg_high   = h;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ph;
        rst   = 1'b1;
        ch_en = '0;
        drive_cfg(1'b0, 2'd0, 1'b0, 8'd0, 8'd0);

        // Reset state
        expect_edge("rst0", 3'b000, 3'b000, 1'b0);
        expect_edge("rst1", 3'b000, 3'b000, 1'b0);
        check_ready("rst_rdy", 1'b1);

        // T1: default div-by-2 on channel 0
        rst   = 1'b0;
        ch_en = 3'b001;
        for (int k = 0; k < 6; k++) begin
            expect_edge($sformatf("t1_k%0d", k),
                        (k % 2 == 0) ? 3'b001 : 3'b000,
                        (k % 2 == 0) ? 3'b001 : 3'b000, 1'b0);
        end
        ch_en = 3'b000;
        expect_edge("t1_off", 3'b000, 3'b000, 1'b0);

        // T2: immediate 5/2 on channel 1
        drive_cfg(1'b1, 2'd1, 1'b1, 8'd5, 8'd2);
        ch_en = 3'b010;
        check_ready("t2_rdy", 1'b1);
        expect_edge("t2_k0", 3'b010, 3'b010, 1'b0);
        drive_cfg(1'b0, 2'd1, 1'b0, 8'd0, 8'd0);
        for (int k = 1; k < 12; k++) begin
            ph = k % 5;
            expect_edge($sformatf("t2_k%0d", k),
                        (ph < 2) ? 3'b010 : 3'b000,
                        (ph == 0) ? 3'b010 : 3'b000, 1'b0);
        end

        // T3: deferred 3/1 requested while cnt==1; the 5-cycle period finishes
        drive_cfg(1'b1, 2'd1, 1'b0, 8'd3, 8'd1);
        check_ready("t3_rdy_pre", 1'b1);
        expect_edge("t3_load", 3'b000, 3'b000, 1'b0);
        drive_cfg(1'b0, 2'd1, 1'b0, 8'd0, 8'd0);
        check_ready("t3_pend0", 1'b0);
        expect_edge("t3_c3", 3'b000, 3'b000, 1'b0);
        check_ready("t3_pend1", 1'b0);
        expect_edge("t3_c4", 3'b000, 3'b000, 1'b0);
        check_ready("t3_pend2", 1'b0);
        expect_edge("t3_apply", 3'b010, 3'b010, 1'b0);
        check_ready("t3_rdy_post", 1'b1);
        for (int k = 1; k < 7; k++) begin
            ph = k % 3;
            expect_edge($sformatf("t3_k%0d", k),
                        (ph == 0) ? 3'b010 : 3'b000,
                        (ph == 0) ? 3'b010 : 3'b000, 1'b0);
        end

        // T4: illegal transfers leave channel 1 running 3/1
        drive_cfg(1'b1, 2'd1, 1'b1, 8'd1, 8'd1);
        expect_edge("t4_per1", 3'b000, 3'b000, 1'b1);
        drive_cfg(1'b0, 2'd1, 1'b0, 8'd0, 8'd0);
        expect_edge("t4_idle0", 3'b000, 3'b000, 1'b0);
        drive_cfg(1'b1, 2'd1, 1'b1, 8'd5, 8'd0);
        expect_edge("t4_high0", 3'b010, 3'b010, 1'b1);
        drive_cfg(1'b0, 2'd1, 1'b0, 8'd0, 8'd0);
        expect_edge("t4_idle1", 3'b000, 3'b000, 1'b0);
        drive_cfg(1'b1, 2'd1, 1'b1, 8'd4, 8'd4);
        expect_edge("t4_higheq", 3'b000, 3'b000, 1'b1);
        drive_cfg(1'b0, 2'd1, 1'b0, 8'd0, 8'd0);
        expect_edge("t4_idle2", 3'b010, 3'b010, 1'b0);
        drive_cfg(1'b1, 2'd3, 1'b1, 8'd5, 8'd2);
        check_ready("t4_rdy_badch", 1'b1);
        expect_edge("t4_badch", 3'b000, 3'b000, 1'b1);
        drive_cfg(1'b0, 2'd1, 1'b0, 8'd0, 8'd0);
        expect_edge("t4_idle3", 3'b000, 3'b000, 1'b0);
        expect_edge("t4_idle4", 3'b010, 3'b010, 1'b0);

        // T5: channel 2 at 5/3, disabled mid-high for 3 cycles
        ch_en = 3'b000;
        drive_cfg(1'b1, 2'd2, 1'b1, 8'd5, 8'd3);
        expect_edge("t5_cfg", 3'b000, 3'b000, 1'b0);
        drive_cfg(1'b0, 2'd2, 1'b0, 8'd0, 8'd0);
        ch_en = 3'b100;
        expect_edge("t5_start", 3'b100, 3'b100, 1'b0);
        expect_edge("t5_h1", 3'b100, 3'b000, 1'b0);
        ch_en = 3'b000;
        expect_edge("t5_off0", 3'b000, 3'b000, 1'b0);
        expect_edge("t5_off1", 3'b000, 3'b000, 1'b0);
        expect_edge("t5_off2", 3'b000, 3'b000, 1'b0);
        ch_en = 3'b100;
        expect_edge("t5_re0", 3'b100, 3'b100, 1'b0);
        expect_edge("t5_re1", 3'b100, 3'b000, 1'b0);
        expect_edge("t5_re2", 3'b100, 3'b000, 1'b0);
        expect_edge("t5_re3", 3'b000, 3'b000, 1'b0);
        expect_edge("t5_re4", 3'b000, 3'b000, 1'b0);
        expect_edge("t5_re5", 3'b100, 3'b100, 1'b0);

        // T6: reset with a pending deferred config on channel 2
        drive_cfg(1'b1, 2'd2, 1'b0, 8'd4, 8'd2);
        expect_edge("t6_load", 3'b100, 3'b000, 1'b0);
        drive_cfg(1'b0, 2'd2, 1'b0, 8'd0, 8'd0);
        check_ready("t6_pend", 1'b0);
        rst = 1'b1;
        expect_edge("t6_rst0", 3'b000, 3'b000, 1'b0);
        check_ready("t6_rst_rdy", 1'b1);
        drive_cfg(1'b1, 2'd2, 1'b1, 8'd7, 8'd3);
        expect_edge("t6_rst1", 3'b000, 3'b000, 1'b0);
        rst = 1'b0;
        drive_cfg(1'b0, 2'd2, 1'b0, 8'd0, 8'd0);
        expect_edge("t6_k0", 3'b100, 3'b100, 1'b0);
        expect_edge("t6_k1", 3'b000, 3'b000, 1'b0);
        expect_edge("t6_k2", 3'b100, 3'b100, 1'b0);
        expect_edge("t6_k3", 3'b000, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_multi_channel_clock_divider
`default_nettype wire
